bin_to_bcd_seq: RTL and testbench

- Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Successor to the fixed 6-bit, 2-digit combinational converter. Adds arbitrary input width and digit count, a start/busy/done handshake, an overflow flag and a leading-zero mask for display blanking.
- Sits between the time/counter registers and the seven-segment digit mux.

---
 rtl/bin_to_bcd_seq.sv | 146 ++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// bin_to_bcd_seq : sequential double-dabble binary-to-BCD converter (1 bit/clk)
// Revision 1.0
// ============================================================================
module bin_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic [DIGITS-1:0]     lz_mask
);

  localparam int CW = $clog2(BIN_W + 1);
  localparam int BW = 4 * DIGITS;

  // 10^DIGITS saturated at 2^BIN_W, which no captured value can reach
  function automatic logic [BIN_W:0] pow10_sat(input int n);
    logic [BIN_W+4:0] p;
    logic [BIN_W+4:0] cap;
    cap        = '0;
    cap[BIN_W] = 1'b1;
    p          = {{(BIN_W+4){1'b0}}, 1'b1};
    for (int i = 0; i < n; i++) begin
      p = p * 4'd10;
      if (p > cap) p = cap;
    end
    return p[BIN_W:0];
  endfunction

  localparam logic [BIN_W:0]    C_POW10  = pow10_sat(DIGITS);
  localparam logic [DIGITS-1:0] C_LZ_RST = {DIGITS{1'b1}} ^ DIGITS'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [BIN_W-1:0]  shift_q, shift_d;
  logic [BW-1:0]     scr_q,   scr_d;
  logic [CW-1:0]     cnt_q,   cnt_d;
  logic              ovfp_q,  ovfp_d;
  logic [BW-1:0]     bcd_q,   bcd_d;
  logic              ovf_q,   ovf_d;
  logic [DIGITS-1:0] lz_q,    lz_d;
  logic              done_q,  done_d;

  logic [BW-1:0]     corr;
  logic [BW-1:0]     scr_shl;
  logic [DIGITS-1:0] lz_next;
  logic              nz_seen;

  // add-3 on every digit from its pre-correction value, then shift in the next bit
  always_comb begin
    corr = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) corr[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
    scr_shl = (corr << 1) | {{(BW-1){1'b0}}, shift_q[BIN_W-1]};
  end

  always_comb begin
    lz_next = '0;
    nz_seen = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (scr_shl[4*i +: 4] != 4'd0) nz_seen = 1'b1;
      lz_next[i] = ~nz_seen;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    ovfp_d  = ovfp_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    lz_d    = lz_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CONV;
          shift_d = bin;
          scr_d   = '0;
          cnt_d   = CW'(BIN_W);
          ovfp_d  = ({1'b0, bin} >= C_POW10);
        end
      end
      S_CONV: begin
        scr_d   = scr_shl;
        shift_d = shift_q << 1;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = scr_shl;
          ovf_d   = ovfp_q;
          lz_d    = lz_next;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      ovfp_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      lz_q    <= C_LZ_RST;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      ovfp_q  <= ovfp_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      lz_q    <= lz_d;
      done_q  <= done_d;
    end
  end

  assign busy    = (state_q == S_CONV);
  assign done    = done_q;
  assign bcd     = bcd_q;
  assign ovf     = ovf_q;
  assign lz_mask = lz_q;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// tb_bin_to_bcd_seq : scoreboard bench for bin_to_bcd_seq in three configurations
// Revision 1.0
// ============================================================================
module tb_bin_to_bcd_seq;

  localparam int W_P[3] = '{8, 8, 6};
  localparam int D_P[3] = '{3, 2, 2};

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
    logic [2:0]  lz;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst   [3];
  logic        start [3];
  logic [7:0]  bin   [3];
  logic        busy_w[3];
  logic        done_w[3];
  logic        ovf_w [3];
  logic [11:0] bcd0;
  logic [7:0]  bcd1, bcd2;
  logic [2:0]  lz0;
  logic [1:0]  lz1, lz2;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t q0[$], q1[$], q2[$];
  exp_t mon_e;
  bit   mon_got;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .bin(bin[0]),
    .busy(busy_w[0]), .done(done_w[0]), .bcd(bcd0), .ovf(ovf_w[0]), .lz_mask(lz0));
  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .bin(bin[1]),
    .busy(busy_w[1]), .done(done_w[1]), .bcd(bcd1), .ovf(ovf_w[1]), .lz_mask(lz1));
  bin_to_bcd_seq #(.BIN_W(6), .DIGITS(2)) u2 (
    .clk(clk), .rst(rst[2]), .start(start[2]), .bin(bin[2][5:0]),
    .busy(busy_w[2]), .done(done_w[2]), .bcd(bcd2), .ovf(ovf_w[2]), .lz_mask(lz2));

  function automatic logic [11:0] get_bcd(int i);
    case (i)
      0:       return bcd0;
      1:       return {4'd0, bcd1};
      default: return {4'd0, bcd2};
    endcase
  endfunction

  function automatic logic [2:0] get_lz(int i);
    case (i)
      0:       return lz0;
      1:       return {1'b0, lz1};
      default: return {1'b0, lz2};
    endcase
  endfunction

  // Reference: decimal digits of v mod 10^d; leading zeros from the digit count of that value
  function automatic exp_t model(int v, int d, int c);
    exp_t e;
    int   pw, m, nd, tmp;
    pw = 1;
    for (int k = 0; k < d; k++) pw = pw * 10;
    m     = v % pw;
    e.ovf = (v >= pw);
    e.cyc = c;
    e.bcd = '0;
    tmp   = m;
    for (int k = 0; k < d; k++) begin
      e.bcd[4*k +: 4] = 4'(tmp % 10);
      tmp = tmp / 10;
    end
    nd = 1;
    for (int t = m; t >= 10; t = t / 10) nd++;
    e.lz = '0;
    for (int k = nd; k < d; k++) e.lz[k] = 1'b1;
    return e;
  endfunction

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d: got %0h expected %0h (t=%0t)", nm, inst, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input exp_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Waits for IDLE, presents start/bin for one edge; expectation queued when exp_it
  task automatic conv(input int i, input int v, input bit exp_it);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    while (busy_w[i] && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) chk("idle_timeout", i, 32'd1, 32'd0);
    start[i] = 1'b1;
    bin[i]   = v[7:0];
    if (exp_it) push(i, model(v, D_P[i], cyc + 1 + W_P[i]));
    @(posedge clk); #1;
    start[i] = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_w[i] === 1'b1) begin
        mon_got = 1'b0;
        case (i)
          0:       if (q0.size() > 0) begin mon_e = q0.pop_front(); mon_got = 1'b1; end
          1:       if (q1.size() > 0) begin mon_e = q1.pop_front(); mon_got = 1'b1; end
          default: if (q2.size() > 0) begin mon_e = q2.pop_front(); mon_got = 1'b1; end
        endcase
        if (!mon_got) begin
          chk("unexpected_done", i, 32'd1, 32'd0);
        end else begin
          chk("bcd",     i, 32'(get_bcd(i)), 32'(mon_e.bcd));
          chk("ovf",     i, 32'(ovf_w[i]),   32'(mon_e.ovf));
          chk("lz_mask", i, 32'(get_lz(i)),  32'(mon_e.lz));
          chk("latency", i, 32'(cyc),        32'(mon_e.cyc));
          chk("busy_at_done", i, 32'(busy_w[i]), 32'd0);
        end
      end
    end
  end

  task automatic check_reset_state(input int i, input logic [2:0] lz_exp);
    chk("rst_busy", i, 32'(busy_w[i]), 32'd0);
    chk("rst_done", i, 32'(done_w[i]), 32'd0);
    chk("rst_bcd",  i, 32'(get_bcd(i)), 32'd0);
    chk("rst_ovf",  i, 32'(ovf_w[i]), 32'd0);
    chk("rst_lz",   i, 32'(get_lz(i)), 32'(lz_exp));
  endtask

  initial begin
    int guard;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; bin[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_reset_state(0, 3'b110);
    check_reset_state(1, 3'b010);
    check_reset_state(2, 3'b010);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    // Directed values, then 255 followed by 59 issued in the done cycle
    conv(0, 0, 1);
    conv(0, 1, 1);
    conv(0, 2, 1);
    conv(0, 4, 1);
    conv(0, 25, 1);
    conv(0, 255, 1);
    conv(0, 59, 1);
    guard = 0;
    @(posedge clk); #1;
    while ((busy_w[0] || q0.size() > 0) && guard < 50) begin @(posedge clk); #1; guard++; end
    repeat (3) @(posedge clk);
    #1;
    e = model(59, 3, 0);
    chk("bcd_hold", 0, 32'(bcd0), 32'(e.bcd));

    // Reset during the 4th conversion edge: no done, outputs cleared
    conv(0, 200, 0);
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b1;
    @(posedge clk); #1;
    check_reset_state(0, 3'b110);
    rst[0] = 1'b0;
    repeat (12) @(posedge clk);
    conv(0, 137, 1);

    // Two-digit overflow cases
    conv(1, 123, 1);
    conv(1, 99, 1);
    conv(1, 100, 1);
    for (int k = 0; k < 20; k++) conv(1, int'($urandom_range(0, 255)), 1);

    // Six-bit full sweep with ignored mid-conversion start pulses
    for (int v = 0; v < 64; v++) begin
      conv(2, v, 1);
      if (v % 13 == 5) begin
        @(posedge clk); #1;
        start[2] = 1'b1;
        bin[2]   = 8'(63 - v);
        @(posedge clk); #1;
        start[2] = 1'b0;
      end
    end

    for (int k = 0; k < 30; k++) conv(0, int'($urandom_range(0, 255)), 1);

    guard = 0;
    while ((q0.size() + q1.size() + q2.size()) > 0 && guard < 300) begin
      @(posedge clk);
      guard++;
    end
    repeat (2) @(posedge clk);
    chk("queue_drained", 0, 32'(q0.size() + q1.size() + q2.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
